// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//
// Boot-time program loader that sits behind the UART receiver.
// The incoming byte stream has two parts:
//   - a 4-byte little-endian word-count header;
//   - the program words, each sent as 4 bytes, least significant byte first.
// Each completed word is written to instruction memory over a req/gnt port,
// starting at BASE_ADDR and counting upward.
//
// Ports
//   i_Clock      clock
//   rst_ni       asynchronous active-low reset
//   i_en         arm level; dropping it aborts a load or acknowledges done/err
//   i_rx_dv      one-cycle byte strobe from the UART receiver
//   i_rx_byte    received byte, valid with i_rx_dv
//   o_mem_req    memory write request, held until i_mem_gnt
//   o_mem_addr   word address of the write
//   o_mem_wdata  32-bit write data
//   i_mem_gnt    memory accepted the write this cycle
//   o_busy       loader is in HDR, DATA or WRITE
//   o_done       load complete (held until i_en drops)
//   o_err        0 none, 1 bad length, 2 overrun, 3 timeout (held until i_en drops)
//   o_word_cnt   number of words written so far
// ---------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter int TO_W      = 24,
    parameter int TIMEOUT   = 2_000_000
) (
    input  logic              i_Clock,
    input  logic              rst_ni,
    input  logic              i_en,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_gnt,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err,
    output logic [ADDR_W:0]   o_word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0]        ERR_LEN     = 2'd1;
    localparam logic [1:0]        ERR_OVERRUN = 2'd2;
    localparam logic [1:0]        ERR_TIMEOUT = 2'd3;
    // Largest legal word count: the whole address space, one full wrap.
    localparam logic [31:0]       MAX_LEN     = 32'(1) << ADDR_W;
    localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    logic [31:0]       r_len;
    logic [31:0]       r_word;
    logic [1:0]        r_byte_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_to_run;      // timeout armed once the first header byte arrives
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_cnt;
    logic              r_hold_valid;
    logic [7:0]        r_hold_byte;
    logic              r_overrun;
    logic              r_abort;       // i_en dropped while a handshake was pending
    logic              r_mem_req;
    logic [31:0]       r_mem_wdata;
    logic              r_done;
    logic [1:0]        r_err;

    logic [31:0]       w_len_shift;
    logic              w_len_bad;
    logic [31:0]       w_word_shift;
    logic [TO_W-1:0]   w_to_inc;
    logic              w_to_expired;
    logic              w_hold_any;
    logic              w_overrun_any;
    logic [7:0]        w_hold_byte;
    logic [ADDR_W:0]   w_word_cnt_inc;
    logic              w_last;

    // Bytes enter at the top and shift down, so after four strobes the
    // first byte received sits in bits [7:0] (little-endian).
    assign w_len_shift  = {i_rx_byte, r_len[31:8]};
    assign w_word_shift = {i_rx_byte, r_word[31:8]};

    // A single magnitude compare also rejects any length whose bits above
    // ADDR_W are set.
    assign w_len_bad    = (w_len_shift == 32'd0) || (w_len_shift > MAX_LEN);

    assign w_to_inc     = (r_to_cnt == {TO_W{1'b1}}) ? r_to_cnt : r_to_cnt + 1'b1;
    assign w_to_expired = (w_to_inc >= TO_LIMIT);

    // A strobe coinciding with the grant behaves as if it had been held
    // already, so no byte is lost at the WRITE -> DATA boundary.
    assign w_hold_any     = r_hold_valid | i_rx_dv;
    assign w_overrun_any  = r_overrun | (r_hold_valid & i_rx_dv);
    assign w_hold_byte    = r_hold_valid ? r_hold_byte : i_rx_byte;

    assign w_word_cnt_inc = r_word_cnt + 1'b1;
    assign w_last         = (32'(w_word_cnt_inc) == r_len);

    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_to_cnt     <= '0;
            r_to_run     <= 1'b0;
            r_addr       <= '0;
            r_word_cnt   <= '0;
            r_hold_valid <= 1'b0;
            r_hold_byte  <= '0;
            r_overrun    <= 1'b0;
            r_abort      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_wdata  <= '0;
            r_done       <= 1'b0;
            r_err        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_state      <= S_HDR;
                        r_len        <= '0;
                        r_byte_cnt   <= '0;
                        r_word_cnt   <= '0;
                        r_addr       <= BASE;
                        r_to_cnt     <= '0;
                        r_to_run     <= 1'b0;
                        r_hold_valid <= 1'b0;
                        r_overrun    <= 1'b0;
                        r_abort      <= 1'b0;
                        r_done       <= 1'b0;
                        r_err        <= '0;
                    end
                end

                S_HDR: begin
                    if (!i_en) begin
                        r_state <= S_IDLE;
                    end else if (i_rx_dv) begin
                        r_len      <= w_len_shift;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_to_cnt   <= '0;
                        r_to_run   <= 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_len_bad) begin
                                r_state <= S_ERR;
                                r_err   <= ERR_LEN;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end else if (r_to_run) begin
                        r_to_cnt <= w_to_inc;
                        if (w_to_expired) begin
                            r_state <= S_ERR;
                            r_err   <= ERR_TIMEOUT;
                        end
                    end
                end

                S_DATA: begin
                    if (!i_en) begin
                        r_state <= S_IDLE;
                    end else if (i_rx_dv) begin
                        r_word     <= w_word_shift;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_to_cnt   <= '0;
                        if (r_byte_cnt == 2'd3) begin
                            r_state     <= S_WRITE;
                            r_mem_req   <= 1'b1;
                            r_mem_wdata <= w_word_shift;
                        end
                    end else begin
                        r_to_cnt <= w_to_inc;
                        if (w_to_expired) begin
                            r_state <= S_ERR;
                            r_err   <= ERR_TIMEOUT;
                        end
                    end
                end

                S_WRITE: begin
                    // Abort is deferred until the pending write is accepted.
                    if (!i_en) begin
                        r_abort <= 1'b1;
                    end
                    if (i_mem_gnt) begin
                        r_mem_req    <= 1'b0;
                        r_addr       <= r_addr + 1'b1;
                        r_word_cnt   <= w_word_cnt_inc;
                        r_hold_valid <= 1'b0;
                        r_overrun    <= 1'b0;
                        if (r_abort || !i_en) begin
                            r_state <= S_IDLE;
                        end else if (w_overrun_any) begin
                            r_state <= S_ERR;
                            r_err   <= ERR_OVERRUN;
                        end else if (w_last) begin
                            // Any held byte is surplus and silently dropped.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            if (w_hold_any) begin
                                r_word     <= {w_hold_byte, r_word[31:8]};
                                r_byte_cnt <= 2'd1;
                            end else begin
                                r_byte_cnt <= 2'd0;
                            end
                        end
                    end else if (i_rx_dv) begin
                        if (r_hold_valid) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_hold_byte  <= i_rx_byte;
                            r_hold_valid <= 1'b1;
                        end
                    end
                    // Timeout is frozen here, but a strobe still restarts it.
                    if (i_rx_dv) begin
                        r_to_cnt <= '0;
                    end
                end

                S_DONE: begin
                    if (!i_en) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end

                S_ERR: begin
                    if (!i_en) begin
                        r_state <= S_IDLE;
                        r_err   <= '0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_WRITE);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader. A table of header vectors covers the
// length check. Hand-written sequences cover the remaining behaviour:
//   - a normal load;
//   - a byte held during a stalled write;
//   - a write overrun;
//   - the inter-byte timeout;
//   - aborts from DATA and from WRITE;
//   - an asynchronous reset during a write.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int ADDR_W  = 4;
    localparam int TO_W    = 12;
    localparam int TIMEOUT = 1000;

    logic              i_Clock;
    logic              rst_ni;
    logic              i_en;
    logic              i_rx_dv;
    logic [7:0]        i_rx_byte;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_gnt;
    logic              o_busy;
    logic              o_done;
    logic [1:0]        o_err;
    logic [ADDR_W:0]   o_word_cnt;

    uart_prog_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0),
        .TO_W      (TO_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_Clock     (i_Clock),
        .rst_ni      (rst_ni),
        .i_en        (i_en),
        .i_rx_dv     (i_rx_dv),
        .i_rx_byte   (i_rx_byte),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_gnt   (i_mem_gnt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_word_cnt  (o_word_cnt)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Write log: every accepted handshake.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    always @(posedge i_Clock) begin
        if (o_mem_req && i_mem_gnt) begin
            wr_addr_q.push_back(o_mem_addr);
            wr_data_q.push_back(o_mem_wdata);
        end
    end

    typedef struct {
        string       name;
        logic [31:0] len;
        logic [1:0]  exp_err;
        logic        exp_busy;
    } hdr_vec_t;

    hdr_vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_Clock);
        #1;
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(posedge i_Clock);
        #1;
        i_rx_dv   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    // Drop i_en for a cycle (back to IDLE) and re-arm.
    task automatic start_run();
        @(posedge i_Clock);
        #1;
        i_en = 1'b0;
        @(posedge i_Clock);
        #1;
        i_en = 1'b1;
    endtask

    task automatic gnt_pulse();
        @(posedge i_Clock);
        #1;
        i_mem_gnt = 1'b1;
        @(posedge i_Clock);
        #1;
        i_mem_gnt = 1'b0;
    endtask

    task automatic run_basic(input string tag);
        wr_addr_q.delete();
        wr_data_q.delete();
        i_mem_gnt = 1'b1;
        start_run();
        send_word(32'd2);
        send_word(32'h4433_2211);
        check({tag, " req 1 cycle after 4th byte"}, 64'(o_mem_req), 64'd1);
        check({tag, " wdata word0"}, 64'(o_mem_wdata), 64'h4433_2211);
        wait_cyc(1);
        check({tag, " req drops, cnt=1"}, {62'(o_word_cnt), 1'b0, o_mem_req}, {62'd1, 2'b00});
        send_word(32'h5566_7788);
        wait_cyc(3);
        check({tag, " writes logged"}, 64'(wr_addr_q.size()), 64'd2);
        check({tag, " write0 addr/data"},
              (wr_addr_q.size() > 0) ? {28'(wr_addr_q[0]), wr_data_q[0]} : 60'hfff_ffff_ffff_ffff,
              {28'd0, 32'h4433_2211});
        check({tag, " write1 addr/data"},
              (wr_addr_q.size() > 1) ? {28'(wr_addr_q[1]), wr_data_q[1]} : 60'hfff_ffff_ffff_ffff,
              {28'd1, 32'h5566_7788});
        check({tag, " done/err/busy/cnt"}, {56'(o_word_cnt), 4'(o_err), 2'(o_busy), 2'(o_done)},
              {56'd2, 4'd0, 2'd0, 2'd1});
        @(posedge i_Clock);
        #1;
        i_en = 1'b0;
        wait_cyc(1);
        check({tag, " done clears on i_en=0"}, 64'(o_done), 64'd0);
        i_mem_gnt = 1'b0;
    endtask

    logic stable;

    initial begin
        vecs[0] = '{"len=0",          32'd0,           2'd1, 1'b0};
        vecs[1] = '{"len=2^A+1",      32'd17,          2'd1, 1'b0};
        vecs[2] = '{"len high bits",  32'h0100_0001,   2'd1, 1'b0};
        vecs[3] = '{"len=0x80000000", 32'h8000_0000,   2'd1, 1'b0};
        vecs[4] = '{"len=2^A",        32'd16,          2'd0, 1'b1};
        vecs[5] = '{"len=1",          32'd1,           2'd0, 1'b1};

        rst_ni    = 1'b0;
        i_en      = 1'b0;
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
        i_mem_gnt = 1'b0;
        wait_cyc(3);
        check("reset outputs",
              {o_mem_req, 4'(o_mem_addr), o_mem_wdata, o_busy, o_done, o_err, 5'(o_word_cnt)},
              45'd0);
        @(negedge i_Clock);
        rst_ni = 1'b1;
        // Strobes in IDLE are ignored.
        send_byte(8'h55);
        check("idle ignores rx", {o_busy, o_err, o_mem_req}, 4'd0);

        // Test 1: normal two-word load.
        run_basic("load");

        // Test 2: header length table.
        for (int v = 0; v < 6; v++) begin
            start_run();
            i_mem_gnt = 1'b1;
            send_word(vecs[v].len);
            check({vecs[v].name, " err"},  64'(o_err),     64'(vecs[v].exp_err));
            check({vecs[v].name, " busy"}, 64'(o_busy),    64'(vecs[v].exp_busy));
            check({vecs[v].name, " req"},  64'(o_mem_req), 64'd0);
        end
        i_mem_gnt = 1'b0;

        // Test 3: stalled write, one byte held and reused.
        start_run();
        send_word(32'd2);
        send_word(32'hA4A3_A2A1);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_Clock);
            #1;
            i_rx_dv   = (i == 20);
            i_rx_byte = 8'hB1;
            if (!(o_mem_req && o_mem_addr == 4'd0 && o_mem_wdata == 32'hA4A3_A2A1)) stable = 1'b0;
        end
        i_rx_dv = 1'b0;
        check("stall req/addr/wdata stable", 64'(stable), 64'd1);
        check("stall no error", 64'(o_err), 64'd0);
        gnt_pulse();
        check("held byte: req/cnt", {60'(o_word_cnt), 4'(o_mem_req)}, {60'd1, 4'd0});
        send_byte(8'hB2);
        send_byte(8'hB3);
        send_byte(8'hB4);
        check("held byte is byte 0", {28'(o_mem_addr), o_mem_wdata}, {28'd1, 32'hB4B3_B2B1});
        check("held word req", 64'(o_mem_req), 64'd1);
        gnt_pulse();
        check("held run done", {o_done, o_err}, 3'b100);

        // Test 3b: second byte during stall -> overrun once granted.
        start_run();
        send_word(32'd2);
        send_word(32'hC4C3_C2C1);
        send_byte(8'hC5);
        send_byte(8'hC6);
        check("overrun pending", {o_mem_req, o_err}, 3'b100);
        gnt_pulse();
        check("overrun err", {o_err, o_busy, o_mem_req}, 4'b1000);

        // Test 4: timeout after 3 data bytes.
        start_run();
        i_mem_gnt = 1'b1;
        send_word(32'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        wait_cyc(TIMEOUT - 1);
        check("timeout not yet", 64'(o_err), 64'd0);
        wait_cyc(1);
        check("timeout err", 64'(o_err), 64'd3);
        @(posedge i_Clock);
        #1;
        i_en = 1'b0;
        wait_cyc(1);
        check("timeout ack", {o_err, o_busy}, 3'd0);

        // Test 5: abort from DATA.
        start_run();
        send_word(32'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        @(posedge i_Clock);
        #1;
        i_en = 1'b0;
        wait_cyc(1);
        check("abort DATA -> idle", {o_busy, o_done, o_err}, 4'd0);

        // Test 5b: abort from WRITE waits for the grant.
        i_mem_gnt = 1'b0;
        start_run();
        send_word(32'd2);
        send_word(32'hD4D3_D2D1);
        @(posedge i_Clock);
        #1;
        i_en = 1'b0;
        wait_cyc(5);
        check("abort WRITE holds req", {o_mem_req, o_busy}, 2'b11);
        gnt_pulse();
        check("abort WRITE -> idle",
              {o_mem_req, o_busy, o_done, o_err, 5'(o_word_cnt)}, {5'd0, 5'd1});

        // Test 6: asynchronous reset during a stalled write.
        start_run();
        send_word(32'd2);
        send_word(32'hE4E3_E2E1);
        check("pre-reset req", 64'(o_mem_req), 64'd1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("async reset outputs",
              {o_mem_req, 4'(o_mem_addr), o_mem_wdata, o_busy, o_done, o_err, 5'(o_word_cnt)},
              45'd0);
        @(negedge i_Clock);
        rst_ni = 1'b1;
        run_basic("reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
